trap_unit: RTL

Sequencer between the exec stage and the CSR file for traps and MRET. It accepts one exception or MRET request and flushes the pipeline until it drains. It then issues a single-cycle update strobe into the CSR file (trap_do_update / xret_do_update plus payload) and hands fetch a redirect PC over a valid/ready handshake.

---
 rtl/trap_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/trap_unit.sv
// ============================================================================
// Module   : trap_unit
// Purpose  : Sequences a trap or MRET between the exec stage and the CSR file.
//            Accepts one request, flushes the pipeline until it drains, emits
//            a single-cycle CSR update strobe with its payload, then hands
//            fetch a redirect PC over a valid/ready handshake.
// Ports    : clk, rst_n (async, active-low)
//            exc_valid/exc_cause/exc_pc/exc_tval, mret_valid   - exec requests
//            pipe_idle                                          - drain status
//            mstatus, mtvec, mepc, privilege_mode               - CSR values
//            busy, flush                                        - pipeline ctl
//            trap_do_update + trap_mcause/trap_mepc/trap_mtval  - trap strobe
//            xret_do_update + xret_new_mstatus/_privilege_mode  - MRET strobe
//            redirect_valid/redirect_pc/redirect_ready          - fetch redirect
// Config   : TRAP_MTVAL_EN - when defined, exc_tval is latched onto
//            trap_mtval; otherwise trap_mtval is tied to zero.
// Widths   : `XLEN / `ALEN, normally from params.svh; defaulted to 32 here.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALEN
`define ALEN 32
`endif

module trap_unit (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exc_valid,
  input  logic [3:0]        exc_cause,
  input  logic [`ALEN-1:0]  exc_pc,
  input  logic [`XLEN-1:0]  exc_tval,
  input  logic              mret_valid,
  input  logic              pipe_idle,
  input  logic [`XLEN-1:0]  mstatus,
  input  logic [`XLEN-1:0]  mtvec,
  input  logic [`XLEN-1:0]  mepc,
  input  logic [1:0]        privilege_mode,
  output logic              busy,
  output logic              flush,
  output logic              trap_do_update,
  output logic [3:0]        trap_mcause,
  output logic [`ALEN-1:0]  trap_mepc,
  output logic [`XLEN-1:0]  trap_mtval,
  output logic              xret_do_update,
  output logic [`XLEN-1:0]  xret_new_mstatus,
  output logic [1:0]        xret_new_privilege_mode,
  output logic              redirect_valid,
  output logic [`ALEN-1:0]  redirect_pc,
  input  logic              redirect_ready
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_COMMIT   = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic               kind_trap;     // 1: trap, 0: MRET
  logic [3:0]         cause_q;
  logic [`ALEN-1:0]   epc_q;
  logic [`XLEN-1:0]   xret_mstatus_q;
  logic [1:0]         xret_priv_q;
  logic [`ALEN-1:0]   target_q;
  logic [`XLEN-1:0]   xret_mstatus_calc;

  // Current privilege is not needed: only M-mode exists, and the MRET target
  // privilege comes from mstatus.MPP. Low PC/tvec bits are masked by design.
  wire unused_ok = &{1'b0, privilege_mode, mtvec, mepc, exc_pc};

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (exc_valid || mret_valid) state_nxt = S_DRAIN;
      S_DRAIN:    if (pipe_idle)               state_nxt = S_COMMIT;
      S_COMMIT:                                state_nxt = S_REDIRECT;
      S_REDIRECT: if (redirect_ready)          state_nxt = S_IDLE;
      default:                                 state_nxt = S_IDLE;
    endcase
  end

  // MRET mstatus: MIE <- MPIE, MPIE <- 1, MPP <- M (only M-mode implemented).
  always_comb begin
    xret_mstatus_calc        = mstatus;
    xret_mstatus_calc[3]     = mstatus[7];
    xret_mstatus_calc[7]     = 1'b1;
    xret_mstatus_calc[12:11] = 2'b11;
  end

  // ---------------------------------------------------------------- payload
  // MRET payload is captured on the DRAIN->COMMIT edge so the strobe payload
  // is fully registered; mstatus cannot change while the pipe is drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_trap      <= 1'b0;
      cause_q        <= '0;
      epc_q          <= '0;
      xret_mstatus_q <= '0;
      xret_priv_q    <= '0;
      target_q       <= '0;
    end else begin
      if (state == S_IDLE) begin
        if (exc_valid) begin
          kind_trap <= 1'b1;
          cause_q   <= exc_cause;
          epc_q     <= {exc_pc[`ALEN-1:1], 1'b0};
        end else if (mret_valid) begin
          kind_trap <= 1'b0;
        end
      end
      if (state == S_DRAIN && pipe_idle) begin
        xret_mstatus_q <= xret_mstatus_calc;
        xret_priv_q    <= mstatus[12:11];
      end
      if (state == S_COMMIT) begin
        target_q <= kind_trap ? {mtvec[`ALEN-1:2], 2'b00}
                              : {mepc[`ALEN-1:1], 1'b0};
      end
    end
  end

`ifdef TRAP_MTVAL_EN
  logic [`XLEN-1:0] tval_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        tval_q <= '0;
    else if (state == S_IDLE && exc_valid) tval_q <= exc_tval;
  end

  assign trap_mtval = tval_q;
`else
  wire unused_tval_ok = &{1'b0, exc_tval};

  assign trap_mtval = '0;
`endif

  // ---------------------------------------------------------------- outputs
  assign busy                    = (state != S_IDLE);
  assign flush                   = (state != S_IDLE);
  assign trap_do_update          = (state == S_COMMIT) &&  kind_trap;
  assign xret_do_update          = (state == S_COMMIT) && !kind_trap;
  assign trap_mcause             = cause_q;
  assign trap_mepc               = epc_q;
  assign xret_new_mstatus        = xret_mstatus_q;
  assign xret_new_privilege_mode = xret_priv_q;
  assign redirect_valid          = (state == S_REDIRECT);
  assign redirect_pc             = target_q;

endmodule

`default_nettype wire
